// File: rtl/alu_group_sequencer_pkg.sv
// rtl/alu_group_sequencer_pkg.sv - shared codes for the ALU-group decoder/sequencer (ALU_MULTICYCLE_EN adds MC_WAIT)
package alu_group_sequencer_pkg;

    // Instruction group field value for ALU instructions
    localparam logic [1:0] GPF_ALU = 2'b11;

    // ARGF operand-mode codes
    localparam logic [1:0] MODE_ALU_RR = 2'b00;
    localparam logic [1:0] MODE_ALU_U4 = 2'b01;
    localparam logic [1:0] MODE_ALU_U8 = 2'b10;
    localparam logic [1:0] MODE_ALU_S8 = 2'b11;

    // ARGB value that turns a U4 form into a 16-bit long-immediate form
    localparam logic [3:0] LONG_IMM_MARK = 4'hF;

    // ALU operation that leaves condition codes untouched
    localparam logic [3:0] ALU_OPX_MOV = 4'h0;

    // ALU A source selectors
    localparam logic [2:0] ALUA_SRCX_REG_A = 3'd0;

    // ALU B source selectors
    localparam logic [2:0] ALUB_SRCX_REG_B = 3'd0;
    localparam logic [2:0] ALUB_SRCX_U4    = 3'd1;
    localparam logic [2:0] ALUB_SRCX_U8    = 3'd2;
    localparam logic [2:0] ALUB_SRCX_S8    = 3'd3;
    localparam logic [2:0] ALUB_SRCX_IMM16 = 3'd4;

    // Register-file sequence selectors
    localparam logic [2:0] REG_SEQX_NONE    = 3'd0;
    localparam logic [2:0] REG_SEQX_LDA_RDB = 3'd1;
    localparam logic [2:0] REG_SEQX_LDA_IMM = 3'd2;

    // Register address sources
    localparam logic [1:0] REGA_ADDRX_ARGA = 2'd0;
    localparam logic [1:0] REGA_ADDRX_RA   = 2'd1;
    localparam logic [2:0] REGB_ADDRX_ARGB = 3'd0;
    localparam logic [2:0] REGB_ADDRX_RB   = 3'd1;

    // Sequencer state codes
    localparam logic [2:0] ALUSEQ_ST_IDLE     = 3'd0;
    localparam logic [2:0] ALUSEQ_ST_DECODE   = 3'd1;
    localparam logic [2:0] ALUSEQ_ST_IMM_WAIT = 3'd2;
    localparam logic [2:0] ALUSEQ_ST_EXECUTE  = 3'd3;
    localparam logic [2:0] ALUSEQ_ST_COMMIT   = 3'd4;
    localparam logic [2:0] ALUSEQ_ST_MC_WAIT  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE     = ALUSEQ_ST_IDLE,
        ST_DECODE   = ALUSEQ_ST_DECODE,
        ST_IMM_WAIT = ALUSEQ_ST_IMM_WAIT,
        ST_EXECUTE  = ALUSEQ_ST_EXECUTE,
        ST_COMMIT   = ALUSEQ_ST_COMMIT
`ifdef ALU_MULTICYCLE_EN
        , ST_MC_WAIT = ALUSEQ_ST_MC_WAIT
`endif
    } alu_seq_state_t;

endpackage

// File: rtl/alu_group_field_decode.sv
// rtl/alu_group_field_decode.sv - combinational ARGF/ARGB to control-word map
module alu_group_field_decode
    import alu_group_sequencer_pkg::*;
#(
    parameter int ARG_W = 4,
    parameter int SRC_W = 3
) (
    input  logic [1:0]       argf,
    input  logic [ARG_W-1:0] argb,
    output logic [SRC_W-1:0] alua_src,
    output logic [SRC_W-1:0] alub_src,
    output logic [2:0]       reg_seq,
    output logic [1:0]       rega_addr,
    output logic [2:0]       regb_addr,
    output logic             long_imm
);

    // Operand mode to source/sequence selection; address sources default to the raw fields
    always_comb begin
        alua_src  = SRC_W'(ALUA_SRCX_REG_A);
        alub_src  = SRC_W'(ALUB_SRCX_REG_B);
        reg_seq   = REG_SEQX_LDA_IMM;
        rega_addr = REGA_ADDRX_ARGA;
        regb_addr = REGB_ADDRX_ARGB;
        long_imm  = 1'b0;
        case (argf)
            MODE_ALU_RR: begin
                reg_seq = REG_SEQX_LDA_RDB;
            end
            MODE_ALU_U4: begin
                if (argb == ARG_W'(LONG_IMM_MARK)) begin
                    alub_src = SRC_W'(ALUB_SRCX_IMM16);
                    long_imm = 1'b1;
                end else begin
                    alub_src = SRC_W'(ALUB_SRCX_U4);
                end
            end
            MODE_ALU_U8: begin
                rega_addr = REGA_ADDRX_RA;
                alub_src  = SRC_W'(ALUB_SRCX_U8);
            end
            default: begin
                rega_addr = REGA_ADDRX_RA;
                regb_addr = REGB_ADDRX_RB;
                alub_src  = SRC_W'(ALUB_SRCX_S8);
            end
        endcase
    end

endmodule

// File: rtl/alu_group_sequencer.sv
// rtl/alu_group_sequencer.sv - registered ALU-group decoder and DECODE/EXECUTE/COMMIT sequencer (optional ALU_MULTICYCLE_EN)
module alu_group_sequencer
    import alu_group_sequencer_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int OPX_W   = 4,
    parameter int ARG_W   = 4,
    parameter int SRC_W   = 3
`ifdef ALU_MULTICYCLE_EN
    , parameter int MC_MAX = 15
`endif
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               INSTR_VALID,
    input  logic [INSTR_W-1:0] INSTRUCTION,
    output logic               INSTR_READY,
    output logic               IMM_REQ,
    input  logic               IMM_VALID,
    input  logic [INSTR_W-1:0] IMM_DATA,
    output logic [OPX_W-1:0]   ALU_OPX,
    output logic [ARG_W-1:0]   ARGA_X,
    output logic [ARG_W-1:0]   ARGB_X,
    output logic [INSTR_W-1:0] IMM_X,
    output logic [SRC_W-1:0]   ALUA_SRCX,
    output logic [SRC_W-1:0]   ALUB_SRCX,
    output logic [2:0]         REG_SEQX,
    output logic [1:0]         REGA_ADDRX,
    output logic [2:0]         REGB_ADDRX,
    output logic               EXEC_STB,
    output logic               COMMIT_STB,
    output logic               CCL_LD,
    output logic               ILLEGAL
`ifdef ALU_MULTICYCLE_EN
    , input  logic             ALU_BUSY,
    output logic               ALU_TIMEOUT
`endif
);

    // Instruction layout: GPF | OPX | ARGF | ARGA | ARGB, MSB to LSB
    logic [1:0]       gpf;
    logic [OPX_W-1:0] opx;
    logic [1:0]       argf;
    logic [ARG_W-1:0] arga;
    logic [ARG_W-1:0] argb;

    assign gpf  = INSTRUCTION[INSTR_W-1 -: 2];
    assign opx  = INSTRUCTION[INSTR_W-3 -: OPX_W];
    assign argf = INSTRUCTION[2*ARG_W +: 2];
    assign arga = INSTRUCTION[ARG_W +: ARG_W];
    assign argb = INSTRUCTION[0 +: ARG_W];

    logic [SRC_W-1:0] dec_alua;
    logic [SRC_W-1:0] dec_alub;
    logic [2:0]       dec_seq;
    logic [1:0]       dec_rega;
    logic [2:0]       dec_regb;
    logic             dec_long;

    alu_group_field_decode #(
        .ARG_W (ARG_W),
        .SRC_W (SRC_W)
    ) u_field_decode (
        .argf      (argf),
        .argb      (argb),
        .alua_src  (dec_alua),
        .alub_src  (dec_alub),
        .reg_seq   (dec_seq),
        .rega_addr (dec_rega),
        .regb_addr (dec_regb),
        .long_imm  (dec_long)
    );

    alu_seq_state_t state;
    logic           long_imm_q;

`ifdef ALU_MULTICYCLE_EN
    localparam int MC_CNT_W = $clog2(MC_MAX + 1);
    logic [MC_CNT_W-1:0] mc_cnt;
`endif

    // Sequencer: state, captured control words and all strobes are registered here
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= ST_IDLE;
            long_imm_q  <= 1'b0;
            INSTR_READY <= 1'b1;
            IMM_REQ     <= 1'b0;
            ALU_OPX     <= '0;
            ARGA_X      <= '0;
            ARGB_X      <= '0;
            IMM_X       <= '0;
            ALUA_SRCX   <= SRC_W'(ALUA_SRCX_REG_A);
            ALUB_SRCX   <= SRC_W'(ALUB_SRCX_REG_B);
            REG_SEQX    <= REG_SEQX_NONE;
            REGA_ADDRX  <= REGA_ADDRX_ARGA;
            REGB_ADDRX  <= REGB_ADDRX_ARGB;
            EXEC_STB    <= 1'b0;
            COMMIT_STB  <= 1'b0;
            CCL_LD      <= 1'b0;
            ILLEGAL     <= 1'b0;
`ifdef ALU_MULTICYCLE_EN
            mc_cnt      <= '0;
            ALU_TIMEOUT <= 1'b0;
`endif
        end else begin
            EXEC_STB   <= 1'b0;
            COMMIT_STB <= 1'b0;
            CCL_LD     <= 1'b0;
            ILLEGAL    <= 1'b0;
`ifdef ALU_MULTICYCLE_EN
            ALU_TIMEOUT <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (INSTR_VALID && INSTR_READY) begin
                        if (gpf == GPF_ALU) begin
                            ALU_OPX     <= opx;
                            ARGA_X      <= arga;
                            ARGB_X      <= argb;
                            ALUA_SRCX   <= dec_alua;
                            ALUB_SRCX   <= dec_alub;
                            REG_SEQX    <= dec_seq;
                            REGA_ADDRX  <= dec_rega;
                            REGB_ADDRX  <= dec_regb;
                            long_imm_q  <= dec_long;
                            INSTR_READY <= 1'b0;
                            state       <= ST_DECODE;
                        end else begin
                            // Foreign group word is consumed but leaves control words untouched
                            ILLEGAL <= 1'b1;
                        end
                    end
                end
                ST_DECODE: begin
                    if (long_imm_q) begin
                        IMM_REQ <= 1'b1;
                        state   <= ST_IMM_WAIT;
                    end else begin
                        EXEC_STB <= 1'b1;
                        state    <= ST_EXECUTE;
                    end
                end
                ST_IMM_WAIT: begin
                    if (IMM_VALID) begin
                        IMM_X    <= IMM_DATA;
                        IMM_REQ  <= 1'b0;
                        EXEC_STB <= 1'b1;
                        state    <= ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
`ifdef ALU_MULTICYCLE_EN
                    if (ALU_BUSY) begin
                        mc_cnt <= '0;
                        state  <= ST_MC_WAIT;
                    end else begin
                        COMMIT_STB <= 1'b1;
                        CCL_LD     <= (ALU_OPX != OPX_W'(ALU_OPX_MOV));
                        state      <= ST_COMMIT;
                    end
`else
                    COMMIT_STB <= 1'b1;
                    CCL_LD     <= (ALU_OPX != OPX_W'(ALU_OPX_MOV));
                    state      <= ST_COMMIT;
`endif
                end
`ifdef ALU_MULTICYCLE_EN
                ST_MC_WAIT: begin
                    if (!ALU_BUSY) begin
                        COMMIT_STB <= 1'b1;
                        CCL_LD     <= (ALU_OPX != OPX_W'(ALU_OPX_MOV));
                        state      <= ST_COMMIT;
                    end else if (mc_cnt == MC_CNT_W'(MC_MAX - 1)) begin
                        // mc_cnt counts completed wait cycles, so this is the MC_MAX-th one
                        ALU_TIMEOUT <= 1'b1;
                        COMMIT_STB  <= 1'b1;
                        state       <= ST_COMMIT;
                    end else begin
                        mc_cnt <= mc_cnt + 1'b1;
                    end
                end
`endif
                ST_COMMIT: begin
                    INSTR_READY <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: begin
                    IMM_REQ     <= 1'b0;
                    INSTR_READY <= 1'b1;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_group_sequencer.sv
// tb/tb_alu_group_sequencer.sv - directed self-checking bench for alu_group_sequencer (ALU_MULTICYCLE_EN adds busy cases)
module tb_alu_group_sequencer;
    import alu_group_sequencer_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        INSTR_VALID = 1'b0;
    logic [15:0] INSTRUCTION = '0;
    logic        INSTR_READY;
    logic        IMM_REQ;
    logic        IMM_VALID = 1'b0;
    logic [15:0] IMM_DATA = '0;
    logic [3:0]  ALU_OPX;
    logic [3:0]  ARGA_X;
    logic [3:0]  ARGB_X;
    logic [15:0] IMM_X;
    logic [2:0]  ALUA_SRCX;
    logic [2:0]  ALUB_SRCX;
    logic [2:0]  REG_SEQX;
    logic [1:0]  REGA_ADDRX;
    logic [2:0]  REGB_ADDRX;
    logic        EXEC_STB;
    logic        COMMIT_STB;
    logic        CCL_LD;
    logic        ILLEGAL;
`ifdef ALU_MULTICYCLE_EN
    logic        ALU_BUSY = 1'b0;
    logic        ALU_TIMEOUT;
`endif

    int n_cmp = 0;
    int n_err = 0;

    alu_group_sequencer dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .INSTR_VALID (INSTR_VALID),
        .INSTRUCTION (INSTRUCTION),
        .INSTR_READY (INSTR_READY),
        .IMM_REQ     (IMM_REQ),
        .IMM_VALID   (IMM_VALID),
        .IMM_DATA    (IMM_DATA),
        .ALU_OPX     (ALU_OPX),
        .ARGA_X      (ARGA_X),
        .ARGB_X      (ARGB_X),
        .IMM_X       (IMM_X),
        .ALUA_SRCX   (ALUA_SRCX),
        .ALUB_SRCX   (ALUB_SRCX),
        .REG_SEQX    (REG_SEQX),
        .REGA_ADDRX  (REGA_ADDRX),
        .REGB_ADDRX  (REGB_ADDRX),
        .EXEC_STB    (EXEC_STB),
        .COMMIT_STB  (COMMIT_STB),
        .CCL_LD      (CCL_LD),
        .ILLEGAL     (ILLEGAL)
`ifdef ALU_MULTICYCLE_EN
        , .ALU_BUSY    (ALU_BUSY),
        .ALU_TIMEOUT (ALU_TIMEOUT)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ready"},  INSTR_READY, 1);
        chk({tag, "_immreq"}, IMM_REQ, 0);
        chk({tag, "_opx"},    ALU_OPX, 0);
        chk({tag, "_arga"},   ARGA_X, 0);
        chk({tag, "_argb"},   ARGB_X, 0);
        chk({tag, "_immx"},   IMM_X, 0);
        chk({tag, "_alua"},   ALUA_SRCX, ALUA_SRCX_REG_A);
        chk({tag, "_alub"},   ALUB_SRCX, ALUB_SRCX_REG_B);
        chk({tag, "_seq"},    REG_SEQX, REG_SEQX_NONE);
        chk({tag, "_rega"},   REGA_ADDRX, REGA_ADDRX_ARGA);
        chk({tag, "_regb"},   REGB_ADDRX, REGB_ADDRX_ARGB);
        chk({tag, "_stbs"},   {EXEC_STB, COMMIT_STB, CCL_LD, ILLEGAL}, 0);
    endtask

    // Accepts one short-form ALU word and checks t1..t4 of its sequence
    task automatic run_plain(input string tag, input logic [15:0] instr,
                             input logic [3:0] e_opx, input logic [3:0] e_arga, input logic [3:0] e_argb,
                             input logic [2:0] e_alub, input logic [2:0] e_seq,
                             input logic [1:0] e_rega, input logic [2:0] e_regb, input logic e_ccl);
        INSTRUCTION = instr;
        INSTR_VALID = 1'b1;
        tick();
        INSTR_VALID = 1'b0;
        chk({tag, "_t1_ready"}, INSTR_READY, 0);
        chk({tag, "_t1_opx"},   ALU_OPX, e_opx);
        chk({tag, "_t1_arga"},  ARGA_X, e_arga);
        chk({tag, "_t1_argb"},  ARGB_X, e_argb);
        chk({tag, "_t1_alua"},  ALUA_SRCX, ALUA_SRCX_REG_A);
        chk({tag, "_t1_alub"},  ALUB_SRCX, e_alub);
        chk({tag, "_t1_seq"},   REG_SEQX, e_seq);
        chk({tag, "_t1_rega"},  REGA_ADDRX, e_rega);
        chk({tag, "_t1_regb"},  REGB_ADDRX, e_regb);
        chk({tag, "_t1_exec"},  EXEC_STB, 0);
        tick();
        chk({tag, "_t2_exec"},   EXEC_STB, 1);
        chk({tag, "_t2_commit"}, COMMIT_STB, 0);
        tick();
        chk({tag, "_t3_exec"},   EXEC_STB, 0);
        chk({tag, "_t3_commit"}, COMMIT_STB, 1);
        chk({tag, "_t3_ccl"},    CCL_LD, e_ccl);
        chk({tag, "_t3_ready"},  INSTR_READY, 0);
        tick();
        chk({tag, "_t4_ready"},  INSTR_READY, 1);
        chk({tag, "_t4_commit"}, COMMIT_STB, 0);
        chk({tag, "_t4_ccl"},    CCL_LD, 0);
    endtask

    initial begin
        tick(2);
        check_reset_values("rst");
        RESET = 1'b1;
        tick();

        // 1 reg-reg
        run_plain("rr", 16'hC812, 4'h2, 4'h1, 4'h2, ALUB_SRCX_REG_B, REG_SEQX_LDA_RDB,
                  REGA_ADDRX_ARGA, REGB_ADDRX_ARGB, 1'b1);
        // short U4 form
        run_plain("u4", 16'hC917, 4'h2, 4'h1, 4'h7, ALUB_SRCX_U4, REG_SEQX_LDA_IMM,
                  REGA_ADDRX_ARGA, REGB_ADDRX_ARGB, 1'b1);
        // 3 S8, then MOV in the same mode
        run_plain("s8", 16'hCB80, 4'h2, 4'h8, 4'h0, ALUB_SRCX_S8, REG_SEQX_LDA_IMM,
                  REGA_ADDRX_RA, REGB_ADDRX_RB, 1'b1);
        run_plain("mov", 16'hC380, 4'h0, 4'h8, 4'h0, ALUB_SRCX_S8, REG_SEQX_LDA_IMM,
                  REGA_ADDRX_RA, REGB_ADDRX_RB, 1'b0);

        // 2 long immediate with 3 cycles of IMM_VALID low
        INSTRUCTION = 16'hC93F;
        INSTR_VALID = 1'b1;
        tick();
        INSTR_VALID = 1'b0;
        chk("li_t1_alub",   ALUB_SRCX, ALUB_SRCX_IMM16);
        chk("li_t1_seq",    REG_SEQX, REG_SEQX_LDA_IMM);
        chk("li_t1_argb",   ARGB_X, 4'hF);
        chk("li_t1_immreq", IMM_REQ, 0);
        IMM_VALID = 1'b1;
        IMM_DATA  = 16'h1234;
        tick();
        IMM_VALID = 1'b0;
        chk("li_ignored_immx", IMM_X, 16'h0000);
        chk("li_t2_immreq",    IMM_REQ, 1);
        chk("li_t2_exec",      EXEC_STB, 0);
        tick();
        chk("li_t3_immreq", IMM_REQ, 1);
        tick();
        chk("li_t4_immreq", IMM_REQ, 1);
        tick();
        chk("li_t5_immreq", IMM_REQ, 1);
        chk("li_t5_exec",   EXEC_STB, 0);
        IMM_VALID = 1'b1;
        IMM_DATA  = 16'hBEEF;
        tick();
        IMM_VALID = 1'b0;
        chk("li_t6_immreq", IMM_REQ, 0);
        chk("li_t6_exec",   EXEC_STB, 1);
        chk("li_t6_immx",   IMM_X, 16'hBEEF);
        tick();
        chk("li_t7_commit", COMMIT_STB, 1);
        chk("li_t7_ccl",    CCL_LD, 1);
        tick();
        chk("li_t8_ready",  INSTR_READY, 1);

        // 4a illegal group
        INSTRUCTION = 16'h4123;
        INSTR_VALID = 1'b1;
        tick();
        INSTR_VALID = 1'b0;
        chk("ill_t1_pulse", ILLEGAL, 1);
        chk("ill_t1_ready", INSTR_READY, 1);
        chk("ill_t1_arga",  ARGA_X, 4'h3);
        chk("ill_t1_alub",  ALUB_SRCX, ALUB_SRCX_IMM16);
        tick();
        chk("ill_t2_pulse", ILLEGAL, 0);
        chk("ill_t2_exec",  EXEC_STB, 0);
        chk("ill_t2_ready", INSTR_READY, 1);
        tick();
        chk("ill_t3_exec",  EXEC_STB, 0);

        // 4b valid held while busy
        INSTRUCTION = 16'hC812;
        INSTR_VALID = 1'b1;
        tick();
        INSTRUCTION = 16'hCA45;
        chk("bp_t1_arga",  ARGA_X, 4'h1);
        chk("bp_t1_ready", INSTR_READY, 0);
        tick();
        chk("bp_t2_arga",  ARGA_X, 4'h1);
        chk("bp_t2_exec",  EXEC_STB, 1);
        tick();
        chk("bp_t3_arga",  ARGA_X, 4'h1);
        chk("bp_t3_commit", COMMIT_STB, 1);
        tick();
        chk("bp_t4_arga",  ARGA_X, 4'h1);
        chk("bp_t4_ready", INSTR_READY, 1);
        tick();
        INSTR_VALID = 1'b0;
        chk("bp_t5_arga",  ARGA_X, 4'h4);
        chk("bp_t5_argb",  ARGB_X, 4'h5);
        chk("bp_t5_alub",  ALUB_SRCX, ALUB_SRCX_U8);
        chk("bp_t5_rega",  REGA_ADDRX, REGA_ADDRX_RA);
        chk("bp_t5_regb",  REGB_ADDRX, REGB_ADDRX_ARGB);
        chk("bp_t5_ready", INSTR_READY, 0);
        tick(3);
        chk("bp_t8_ready", INSTR_READY, 1);

        // 5 reset during IMM_WAIT
        INSTRUCTION = 16'hC93F;
        INSTR_VALID = 1'b1;
        tick();
        INSTR_VALID = 1'b0;
        tick();
        chk("rst_pre_immreq", IMM_REQ, 1);
        RESET = 1'b0;
        #1;
        check_reset_values("rstmid");
        tick();
        RESET = 1'b1;
        IMM_VALID = 1'b1;
        IMM_DATA  = 16'hDEAD;
        tick();
        IMM_VALID = 1'b0;
        chk("rst_post_immx",   IMM_X, 16'h0000);
        chk("rst_post_immreq", IMM_REQ, 0);
        run_plain("rr2", 16'hC812, 4'h2, 4'h1, 4'h2, ALUB_SRCX_REG_B, REG_SEQX_LDA_RDB,
                  REGA_ADDRX_ARGA, REGB_ADDRX_ARGB, 1'b1);

`ifdef ALU_MULTICYCLE_EN
        // 6a busy for 5 cycles
        INSTRUCTION = 16'hC812;
        INSTR_VALID = 1'b1;
        tick();
        INSTR_VALID = 1'b0;
        tick();
        ALU_BUSY = 1'b1;
        chk("mc_t2_exec", EXEC_STB, 1);
        tick(4);
        chk("mc_t6_commit", COMMIT_STB, 0);
        tick();
        ALU_BUSY = 1'b0;
        chk("mc_t7_commit", COMMIT_STB, 0);
        tick();
        chk("mc_t8_commit",  COMMIT_STB, 1);
        chk("mc_t8_ccl",     CCL_LD, 1);
        chk("mc_t8_timeout", ALU_TIMEOUT, 0);
        tick();
        chk("mc_t9_ready", INSTR_READY, 1);

        // 6b busy stuck
        INSTRUCTION = 16'hC812;
        INSTR_VALID = 1'b1;
        tick();
        INSTR_VALID = 1'b0;
        tick();
        ALU_BUSY = 1'b1;
        tick(15);
        chk("to_t17_commit",  COMMIT_STB, 0);
        chk("to_t17_timeout", ALU_TIMEOUT, 0);
        tick();
        chk("to_t18_commit",  COMMIT_STB, 1);
        chk("to_t18_timeout", ALU_TIMEOUT, 1);
        chk("to_t18_ccl",     CCL_LD, 0);
        ALU_BUSY = 1'b0;
        tick();
        chk("to_t19_timeout", ALU_TIMEOUT, 0);
        chk("to_t19_ready",   INSTR_READY, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
